// File: rtl/dds_pkg.sv
// dds_pkg: shared types, constants and mix-to-DAC conversion for the voice scheduler
package dds_pkg;
  localparam int DW_DEF = 16;
  localparam logic [DW_DEF-1:0] MIDSCALE = {1'b1, {DW_DEF-1{1'b0}}};
  localparam logic signed [39:0] SMAX = (40'sd1 <<< (DW_DEF - 1)) - 40'sd1;
  localparam logic signed [39:0] SMIN = -(40'sd1 <<< (DW_DEF - 1));
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } sched_state_t;
  function automatic logic [DW_DEF-1:0] sat_to_ob(input logic signed [39:0] acc, input int shift);
    logic signed [39:0] s;
    logic [DW_DEF-1:0] c;
    s = acc >>> shift;
    c = s > SMAX ? SMAX[DW_DEF-1:0] : s < SMIN ? SMIN[DW_DEF-1:0] : s[DW_DEF-1:0];
    return {~c[DW_DEF-1], c[DW_DEF-2:0]};
  endfunction
endpackage

// File: rtl/dds_voice_sched_if.sv
// dds_voice_sched_if: oscillator-core request/done and DAC valid/ready signals
interface dds_voice_sched_if #(
  parameter int NV = 4,
  parameter int DW = dds_pkg::DW_DEF
);
  localparam int VW = NV > 1 ? $clog2(NV) : 1;
  logic          dp_start;
  logic [VW-1:0] dp_voice;
  logic          dp_done;
  logic [DW-1:0] dp_sample;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic          dac_ready;
  modport master (
    output dp_start, dp_voice, dac_data, dac_valid,
    input  dp_done, dp_sample, dac_ready
  );
  modport slave (
    input  dp_start, dp_voice, dac_data, dac_valid,
    output dp_done, dp_sample, dac_ready
  );
endinterface

// File: rtl/dds_tick_div.sv
// dds_tick_div: sample-rate divider emitting a one-cycle tick every max(rate_div,1) clocks
module dds_tick_div (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rate_div_i,
  output logic        tick_o
);
  logic [15:0] cnt_q, cnt_d, term_q, term_d, term_new;
  assign term_new = rate_div_i == 16'd0 ? 16'd0 : rate_div_i - 16'd1;
  assign tick_o   = cnt_q == term_q;
  assign cnt_d    = tick_o ? 16'd0 : cnt_q + 16'd1;
  // the terminal value is only re-sampled at wrap so a new rate never truncates a period
  assign term_d   = tick_o ? term_new : term_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 16'd0;
      term_q <= term_new;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end
endmodule

// File: rtl/dds_voice_sched.sv
// dds_voice_sched: per-tick voice scan, mix accumulation and DAC word handoff
module dds_voice_sched
  import dds_pkg::*;
#(
  parameter int NV        = 4,
  parameter int DW        = DW_DEF,
  parameter int MIX_SHIFT = 2,
  parameter int TMO       = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NV-1:0] voice_en_i,
  input  logic [15:0]   rate_div_i,
  input  logic          clr_err_i,
  dds_voice_sched_if.master bus,
  output logic          busy_o,
  output logic          ovr_err_o,
  output logic          tmo_err_o
);
  localparam int VW = NV > 1 ? $clog2(NV) : 1;
  localparam int TW = TMO > 0 ? $clog2(TMO + 1) : 1;
  localparam int AW = DW + VW;
  sched_state_t state_q, state_d;
  logic [NV-1:0] en_q, en_d;
  logic [VW-1:0] vidx_q, vidx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DW-1:0] dac_data_q, dac_data_d;
  logic dac_valid_q, dac_valid_d, ovr_q, ovr_d, terr_q, terr_d, tmo_hit, tick, last;
  dds_tick_div u_div (.clk(clk), .rst(rst), .rate_div_i(rate_div_i), .tick_o(tick));
  assign last = vidx_q == VW'(NV - 1);
  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    vidx_d      = vidx_q;
    acc_d       = acc_q;
    tmo_d       = tmo_q;
    dac_data_d  = dac_data_q;
    dac_valid_d = dac_valid_q;
    tmo_hit     = 1'b0;
    case (state_q)
      S_IDLE: if (tick) begin
        state_d = S_SCAN;
        en_d    = voice_en_i;
        acc_d   = '0;
        vidx_d  = '0;
      end
      S_SCAN: begin
        state_d = en_q[vidx_q] ? S_ISSUE : last ? S_OUT : S_SCAN;
        vidx_d  = en_q[vidx_q] || last ? vidx_q : vidx_q + VW'(1);
      end
      S_ISSUE: begin
        tmo_d   = TW'(TMO);
        state_d = S_WAIT;
      end
      // a done arriving with the expiring count still counts as a completed voice
      S_WAIT: if (bus.dp_done || tmo_q == '0) begin
        acc_d   = bus.dp_done ? acc_q + {{VW{bus.dp_sample[DW-1]}}, bus.dp_sample} : acc_q;
        tmo_hit = !bus.dp_done;
        state_d = last ? S_OUT : S_SCAN;
        vidx_d  = last ? vidx_q : vidx_q + VW'(1);
      end else tmo_d = tmo_q - TW'(1);
      S_OUT: if (bus.dac_ready) begin
        state_d     = S_IDLE;
        dac_valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_OUT && state_d == S_OUT) begin
      dac_valid_d = 1'b1;
      dac_data_d  = sat_to_ob(40'(acc_d), MIX_SHIFT);
    end
    ovr_d  = (tick && state_q != S_IDLE) || (ovr_q && !clr_err_i);
    terr_d = tmo_hit || (terr_q && !clr_err_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      en_q        <= '0;
      vidx_q      <= '0;
      acc_q       <= '0;
      tmo_q       <= '0;
      dac_data_q  <= {1'b1, {DW-1{1'b0}}};
      dac_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      vidx_q      <= vidx_d;
      acc_q       <= acc_d;
      tmo_q       <= tmo_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      ovr_q       <= ovr_d;
      terr_q      <= terr_d;
    end
  end
  assign bus.dp_start  = state_q == S_ISSUE;
  assign bus.dp_voice  = vidx_q;
  assign bus.dac_data  = dac_data_q;
  assign bus.dac_valid = dac_valid_q;
  assign busy_o        = state_q != S_IDLE;
  assign ovr_err_o     = ovr_q;
  assign tmo_err_o     = terr_q;
endmodule

// File: tb/tb_dds_voice_sched.sv
// tb_dds_voice_sched: table-driven and randomized frames against a behavioural mix model
module tb_dds_voice_sched;
  logic clk, rst, clr_err, dac_ready, dp_done;
  logic [3:0] voice_en;
  logic [15:0] rate_div, sample;
  logic busy, ovr, tmo, busy_b, ovr_b, tmo_b;
  logic [63:0] samp;
  int errors = 0, checks = 0, nstart = 0, lat = 3;
  bit resp_on = 1;
  int voices[$];

  typedef struct packed {
    logic [3:0]  en;
    logic [63:0] s;
    logic [15:0] e2;
    logic [15:0] e0;
  } vec_t;
  vec_t tbl[8];

  dds_voice_sched_if #(.NV(4), .DW(16)) ifa ();
  dds_voice_sched_if #(.NV(4), .DW(16)) ifb ();
  assign ifa.dp_done = dp_done;
  assign ifa.dp_sample = sample;
  assign ifa.dac_ready = dac_ready;
  assign ifb.dp_done = dp_done;
  assign ifb.dp_sample = sample;
  assign ifb.dac_ready = dac_ready;

  dds_voice_sched #(.MIX_SHIFT(2)) dut_a (
    .clk(clk), .rst(rst), .voice_en_i(voice_en), .rate_div_i(rate_div), .clr_err_i(clr_err),
    .bus(ifa.master), .busy_o(busy), .ovr_err_o(ovr), .tmo_err_o(tmo));
  dds_voice_sched #(.MIX_SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .voice_en_i(voice_en), .rate_div_i(rate_div), .clr_err_i(clr_err),
    .bus(ifb.master), .busy_o(busy_b), .ovr_err_o(ovr_b), .tmo_err_o(tmo_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sum of enabled signed samples, floor-divided by 2^sh, clamped, offset by half scale
  function automatic logic [15:0] model(input logic [3:0] en, input logic [63:0] s, input int sh);
    longint sum;
    sum = 0;
    for (int i = 0; i < 4; i++) if (en[i]) sum += longint'($signed(s[16*i +: 16]));
    sum = sum >>> sh;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return 16'(sum + 32768);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " dut_a"}, {ifa.dp_start, ifa.dp_voice, ifa.dac_data, ifa.dac_valid, busy, ovr, tmo},
        {1'b0, 2'd0, 16'h8000, 4'b0});
    chk({nm, " dut_b"}, {ifb.dp_start, ifb.dp_voice, ifb.dac_data, ifb.dac_valid, busy_b, ovr_b, tmo_b},
        {1'b0, 2'd0, 16'h8000, 4'b0});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset values");
    voices.delete();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int cap, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ifa.dac_valid && n < cap);
  endtask

  task automatic wait_start(input int cap, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ifa.dp_start && n < cap);
  endtask

  task automatic frame(input logic [3:0] en, input logic [63:0] s, input logic [15:0] e2,
                       input logic [15:0] e0, input string nm);
    int n, k;
    bit ok;
    voice_en = en;
    samp = s;
    wait_valid(200, n);
    chk({nm, " valid"}, ifa.dac_valid, 1'b1);
    chk({nm, " data shift2"}, ifa.dac_data, e2);
    chk({nm, " data shift0"}, ifb.dac_data, e0);
    ok = 1;
    k = 0;
    for (int i = 0; i < 4; i++) if (en[i]) begin
      if (k >= voices.size() || voices[k] != i) ok = 0;
      k++;
    end
    if (voices.size() != k) ok = 0;
    chk({nm, " voice order"}, ok, 1'b1);
    voices.delete();
  endtask

  // oscillator core: answers each request lat cycles later with that voice's sample
  initial forever begin
    int v;
    @(posedge clk);
    #1;
    if (ifa.dp_start) begin
      nstart++;
      voices.push_back(int'(ifa.dp_voice));
      if (resp_on) begin
        v = int'(ifa.dp_voice);
        repeat (lat) @(posedge clk);
        #1;
        dp_done = 1'b1;
        sample = samp[16*v +: 16];
        @(posedge clk);
        #1;
        dp_done = 1'b0;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] d;
    logic [63:0] rs;
    logic [3:0] re;
    bit ok;
    tbl[0] = '{4'b0000, 64'h0, 16'h8000, 16'h8000};
    tbl[1] = '{4'b0101, {16'h0, 16'h0800, 16'h0, 16'h1000}, 16'h8600, 16'h9800};
    tbl[2] = '{4'b1111, {4{16'h7FFF}}, 16'hFFFF, 16'hFFFF};
    tbl[3] = '{4'b1111, {4{16'h8000}}, 16'h0000, 16'h0000};
    tbl[4] = '{4'b0011, {16'h0, 16'h0, 16'h0001, 16'h7FFF}, 16'hA000, 16'hFFFF};
    tbl[5] = '{4'b1000, {16'hFFFF, 16'h0, 16'h0, 16'h0}, 16'h7FFF, 16'h7FFF};
    tbl[6] = '{4'b0110, {16'h0, 16'hC000, 16'hC000, 16'h0}, 16'h6000, 16'h0000};
    tbl[7] = '{4'b1001, {16'hFF00, 16'h0, 16'h0, 16'h0100}, 16'h8000, 16'h8000};
    rst = 1'b1; clr_err = 1'b0; dac_ready = 1'b1; dp_done = 1'b0; sample = '0; samp = '0;
    voice_en = 4'b0000; rate_div = 16'd10;
    do_reset();
    nstart = 0;
    wait_valid(100, n);
    chk("idle frame valid", ifa.dac_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_valid(100, n);
      chk("idle frame period", n, 10);
      chk("idle frame data", ifa.dac_data, 16'h8000);
    end
    chk("idle frame dp_start count", nstart, 0);

    rate_div = 16'd40; voice_en = 4'b0001; samp = 64'h1234;
    do_reset();
    wait_start(100, n);
    chk("tick to dp_start latency", n, 41);
    frame(4'b0001, 64'h1234, model(4'b0001, 64'h1234, 2), model(4'b0001, 64'h1234, 0), "latency frame");
    for (int i = 0; i < 8; i++)
      frame(tbl[i].en, tbl[i].s, tbl[i].e2, tbl[i].e0, $sformatf("table %0d", i));
    for (int i = 0; i < 20; i++) begin
      re = 4'($urandom);
      rs = {$urandom, $urandom};
      lat = $urandom_range(1, 5);
      frame(re, rs, model(re, rs, 2), model(re, rs, 0), $sformatf("random %0d", i));
    end
    lat = 3;
    chk("no overrun at steady rate", {ovr, tmo}, 2'b00);

    resp_on = 0; voice_en = 4'b0001;
    wait_start(100, n);
    chk("rst test dp_start", ifa.dp_start, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; dp_done = 1'b1; sample = 16'h7FFF;
    @(posedge clk);
    #1;
    chk_reset("rst during WAIT");
    rst = 1'b0; dp_done = 1'b0; resp_on = 1;
    voices.delete();
    frame(4'b0101, 64'h0000_0400_0000_0400, 16'h8200, 16'h8800, "after rst frame");

    rate_div = 16'd200; voice_en = 4'b0010; resp_on = 0;
    do_reset();
    wait_start(300, n);
    chk("timeout dp_voice", {ifa.dp_start, ifa.dp_voice}, 3'b101);
    repeat (64) begin @(posedge clk); #1; end
    chk("tmo_err before expiry", tmo, 1'b0);
    @(posedge clk);
    #1;
    chk("tmo_err after TMO+1 waits", tmo, 1'b1);
    wait_valid(20, n);
    chk("timeout frame data", ifa.dac_data, 16'h8000);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("tmo_err cleared", tmo, 1'b0);
    resp_on = 1;

    rate_div = 16'd4; voice_en = 4'b0000; dac_ready = 1'b0;
    do_reset();
    wait_valid(50, n);
    d = ifa.dac_data;
    chk("stall word", {ifa.dac_valid, d}, {1'b1, 16'h8000});
    ok = 1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!ifa.dac_valid || ifa.dac_data !== d) ok = 0;
    end
    chk("stall stable", ok, 1'b1);
    chk("ovr_err on stall", ovr, 1'b1);
    dac_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("accept on ready", {ifa.dac_valid, busy, ifa.dac_data}, {1'b0, 1'b0, 16'h8000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
